// File: rtl/serial_word_deser.sv
// serial_word_deser: serial-to-parallel receiver with a one-entry valid/ready
// output buffer. Bits arrive one per qualified clock (sin_valid); sin_start
// resynchronises to a new word boundary mid-stream.
//
// state | meaning
// IDLE  | no partial word held, bit_cnt = 0
// SHIFT | partial word in progress, 1 <= bit_cnt <= WIDTH-1

module serial_word_deser #(
    parameter int WIDTH     = 23,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;

    // shifted: register after accepting sin; fresh: a new word holding only sin
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;
    logic             complete;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {shreg[WIDTH-2:0], sin};
            assign fresh   = {{(WIDTH-1){1'b0}}, sin};
        end else begin : g_lsb
            assign shifted = {sin, shreg[WIDTH-1:1]};
            assign fresh   = {sin, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // A start bit always wins over completion, so a word only completes without it.
    assign complete = sin_valid && (state == SHIFT) && !sin_start && (bit_cnt == LAST_CNT);

    // Receive FSM: shift register, bit counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (sin_valid) begin
            case (state)
                IDLE: begin
                    shreg   <= shifted;
                    bit_cnt <= ONE_CNT;
                    state   <= SHIFT;
                    busy    <= 1'b1;
                end
                SHIFT: begin
                    if (sin_start) begin
                        shreg   <= fresh;
                        bit_cnt <= ONE_CNT;
                    end else if (bit_cnt == LAST_CNT) begin
                        shreg   <= shifted;
                        bit_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + ONE_CNT;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output buffer; a completing word may replace a word consumed on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (complete && (!out_valid || out_ready)) begin
            out_data  <= shifted;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun: set on a dropped word, set beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (complete && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_deser.sv
// Scoreboard bench for serial_word_deser. Two instances share one stimulus
// stream: dut_m is MSB first, dut_l is LSB first, so dut_l expects the
// bit-reversed word.

module tb_serial_word_deser;

    localparam int W = 23;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_start = 1'b0;
    logic         out_ready = 1'b0;
    logic         ovr_clr = 1'b0;

    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int popped_m = 0;
    int popped_l = 0;

    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];

    always #5 clk = ~clk;

    serial_word_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
        .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
        .busy(busy_m), .overrun(ovr_m), .ovr_clr(ovr_clr)
    );

    serial_word_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
        .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
        .busy(busy_l), .overrun(ovr_l), .ovr_clr(ovr_clr)
    );

    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [W-1:0] w);
        q_m.push_back(w);
        q_l.push_back(rev(w));
        pushed++;
    endtask

    // Drives one full word MSB first on the wire; optionally raises out_ready
    // together with the final bit. Returns 1 time unit after the last edge.
    task automatic send_word(input logic [W-1:0] w, input bit start_first,
                             input bit ready_on_last, input bit chk_busy);
        for (int i = W - 1; i >= 0; i--) begin
            sin       = w[i];
            sin_valid = 1'b1;
            sin_start = start_first && (i == W - 1);
            if (ready_on_last && i == 0) out_ready = 1'b1;
            @(posedge clk); #1;
            if (chk_busy) chk("busy_m", {31'd0, busy_m}, {31'd0, (i != 0)});
        end
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [W-1:0] w);
        for (int i = 0; i < n; i++) begin
            sin       = w[W-1-i];
            sin_valid = 1'b1;
            sin_start = 1'b0;
            @(posedge clk); #1;
        end
        sin_valid = 1'b0;
    endtask

    // Monitor: one pop per accepted word (valid & ready at the coming edge).
    always @(negedge clk) begin
        if (!rst && valid_m && out_ready) begin
            popped_m++;
            if (q_m.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon_m: unexpected word %h", data_m);
            end else chk("mon_m_data", {9'd0, data_m}, {9'd0, q_m.pop_front()});
        end
        if (!rst && valid_l && out_ready) begin
            popped_l++;
            if (q_l.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon_l: unexpected word %h", data_l);
            end else chk("mon_l_data", {9'd0, data_l}, {9'd0, q_l.pop_front()});
        end
    end

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_valid", {30'd0, valid_m, valid_l}, 32'd0);
        chk("rst_data",  {9'd0, data_m | data_l}, 32'd0);
        chk("rst_busy",  {30'd0, busy_m, busy_l}, 32'd0);
        chk("rst_ovr",   {30'd0, ovr_m, ovr_l}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic MSB-first word with a permanently ready consumer
        out_ready = 1'b1;
        expect_word(23'h5A5A5A);
        send_word(23'h5A5A5A, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_hi", {31'd0, valid_m}, 32'd1);
        chk("t1_data", {9'd0, data_m}, {9'd0, 23'h5A5A5A});
        @(posedge clk); #1;
        chk("t1_valid_lo", {30'd0, valid_m, valid_l}, 32'd0);
        chk("t1_ovr", {30'd0, ovr_m, ovr_l}, 32'd0);

        // First wire bit = 1 only: LSB-first instance sees 23'h000001
        expect_word(23'h400000);
        send_word(23'h400000, 1'b0, 1'b0, 1'b0);
        chk("t2_lsb_data", {9'd0, data_l}, 32'h000001);
        @(posedge clk); #1;

        // Stalled consumer: second word is dropped and overrun set
        out_ready = 1'b0;
        expect_word(23'h7FFFFF);
        send_word(23'h7FFFFF, 1'b0, 1'b0, 1'b0);
        chk("t3_ovr_first", {30'd0, ovr_m, ovr_l}, 32'd0);
        send_word(23'h000123, 1'b0, 1'b0, 1'b0);
        chk("t3_ovr_set", {30'd0, ovr_m, ovr_l}, 32'd3);
        chk("t3_data_held", {9'd0, data_m}, {9'd0, 23'h7FFFFF});
        chk("t3_valid_held", {30'd0, valid_m, valid_l}, 32'd3);
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", {30'd0, ovr_m, ovr_l}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_drained", {30'd0, valid_m, valid_l}, 32'd0);

        // Consume and complete on the same edge
        out_ready = 1'b0;
        expect_word(23'h111111);
        send_word(23'h111111, 1'b0, 1'b0, 1'b0);
        expect_word(23'h222222);
        send_word(23'h222222, 1'b0, 1'b1, 1'b0);
        chk("t4_valid", {30'd0, valid_m, valid_l}, 32'd3);
        chk("t4_data", {9'd0, data_m}, {9'd0, 23'h222222});
        chk("t4_ovr", {30'd0, ovr_m, ovr_l}, 32'd0);
        @(posedge clk); #1;
        chk("t4_valid_lo", {30'd0, valid_m, valid_l}, 32'd0);

        // Resync: 10 stale bits, then a start-marked word
        send_bits(10, 23'h7FFFFF);
        chk("t5_busy_mid", {30'd0, busy_m, busy_l}, 32'd3);
        expect_word(23'h3C3C3C);
        send_word(23'h3C3C3C, 1'b1, 1'b0, 1'b0);
        chk("t5_data", {9'd0, data_m}, {9'd0, 23'h3C3C3C});
        @(posedge clk); #1;
        chk("t5_pops", popped_m, pushed);

        // Reset mid-word with a buffered word and overrun set
        out_ready = 1'b0;
        send_word(23'h0ABCDE, 1'b0, 1'b0, 1'b0);
        send_word(23'h155555, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_ovr", {30'd0, ovr_m, ovr_l}, 32'd3);
        send_bits(12, 23'h2AAAAA);
        chk("t6_pre_busy", {30'd0, busy_m, busy_l}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", {30'd0, valid_m, valid_l}, 32'd0);
        chk("t6_data", {9'd0, data_m | data_l}, 32'd0);
        chk("t6_busy", {30'd0, busy_m, busy_l}, 32'd0);
        chk("t6_ovr", {30'd0, ovr_m, ovr_l}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_word(23'h6DB6DB);
        send_word(23'h6DB6DB, 1'b0, 1'b0, 1'b0);
        chk("t6_data_after", {9'd0, data_m}, {9'd0, 23'h6DB6DB});
        repeat (3) @(posedge clk);
        #1;

        chk("end_pops_m", popped_m, pushed);
        chk("end_pops_l", popped_l, pushed);
        chk("end_q_empty", q_m.size() + q_l.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_deser.md
# serial_word_deser

Serial-to-parallel receiver for the 23-bit left-shift serial stream used in the datapath. It accepts one bit per qualified clock, assembles WIDTH-bit words (MSB first by default), and presents each completed word through a one-entry valid/ready output buffer. It sits at the far end of a serial link whose transmitter shifts a parallel word left and emits the MSB each cycle.

## Interface
- WIDTH, 23, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1: the first received bit lands in bit WIDTH-1; 0: the first received bit lands in bit 0.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on this edge only when high.
- sin_start  in  1  qualified by sin_valid; marks the current bit as the first bit of a new word.
- out_data  out  WIDTH  completed word; held stable while out_valid=1 and out_ready=0.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data on an edge where out_valid=1 and out_ready=1.
- busy  out  1  a partial word is in progress (state SHIFT).
- overrun  out  1  sticky flag: a completed word was dropped.
- ovr_clr  in  1  synchronous clear of overrun.

## Operation
- Reset values, all outputs and internal state: shreg=0, bit_cnt=0, state=IDLE, out_data=0, out_valid=0, busy=0, overrun=0.
- Shift rule:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
  - shreg and bit_cnt change only on edges where sin_valid=1.
- bit_cnt width is ceil(log2(WIDTH+1)); it counts bits accepted into the current word.
- FSM states:
  - IDLE (bit_cnt=0): on sin_valid, shift in the bit, bit_cnt=1, go to SHIFT. sin_start is irrelevant here.
  - SHIFT: on sin_valid with sin_start=1, discard the partial word. The current bit becomes bit 1 of a new word (shreg holds only this bit, other bits 0), and bit_cnt=1.
  - SHIFT: on sin_valid with sin_start=0 and bit_cnt<WIDTH-1, shift in the bit and increment bit_cnt.
  - SHIFT: on sin_valid with sin_start=0 and bit_cnt=WIDTH-1, the word is complete. The assembled value (shreg including this bit) goes to the output stage, bit_cnt=0, and the FSM returns to IDLE.
- Output stage, on a completion edge:
  - If out_valid=0, or out_valid=1 and out_ready=1 on the same edge: load out_data and set out_valid=1.
  - Else: keep the old out_data, drop the new word, and set overrun=1.
- Output stage, on an edge with no completion: out_valid=1 and out_ready=1 gives out_valid=0; out_data keeps its value.
- busy = (state==SHIFT).
- overrun stays set until ovr_clr=1 or reset. If ovr_clr and a new overrun occur on the same edge, overrun=1 (set wins).
- sin_start with sin_valid=0 is ignored.
- With sin_start=1 while bit_cnt=WIDTH-1, the start wins: no completion and no overrun.
- Reset asserted mid-word or mid-handshake clears everything immediately; the partial word and the buffered word are lost.

## Timing
- Latency: last bit sampled on edge N gives out_valid=1 and the new out_data visible right after edge N, one edge after the final bit.
- Full throughput: one word every WIDTH qualified edges, with no idle gap between words.
- A consumer that holds out_ready=1 continuously never causes overrun.
- sin_valid gaps of any length are allowed; partial state is held across them.
- No combinational path from out_ready to out_valid or out_data; all outputs are registered.

## Test plan
- Reset, then shift in 23 bits of 23'h5A5A5A MSB first with sin_valid=1 and out_ready=1 -> out_valid pulses for exactly one cycle after the 23rd edge, out_data=23'h5A5A5A, busy high during bits 1..22, overrun=0.
- MSB_FIRST=0, shift in 23'h000001 LSB first, i.e. sin=1 on the first bit -> out_data=23'h000001.
- out_ready=0, send two back-to-back words 23'h7FFFFF then 23'h000123 -> out_data stays 23'h7FFFFF, overrun=1 after the second word's last bit. ovr_clr=1 for one cycle clears overrun to 0.
- Simultaneous consume and complete: out_valid=1 with 23'h111111 buffered, out_ready=1 on the same edge that word 23'h222222 completes -> out_valid stays 1, out_data=23'h222222, overrun=0.
- Resync: send 10 bits, then assert sin_start with sin_valid on the next bit and follow with 22 more bits of 23'h3C3C3C -> out_data=23'h3C3C3C. The 10 stale bits are lost and only one out_valid pulse occurs.
- Assert rst mid-word (bit 12) and while out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. A following full word is received correctly.
